// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader: state encoding and
// default memory geometry.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    ERR   = 3'd4
  } ld_state_e;

  localparam int LD_MEM_DEPTH = 256;
  localparam int LD_ADDR_W    = 8;

  // First state after an accepted start: zero-fill first, or load directly.
  function automatic ld_state_e ld_first_state(input logic clear_en);
    return clear_en ? CLEAR : LOAD;
  endfunction

endpackage

// File: rtl/ld_addr_gen.sv
// Shared address counter used as the clear pointer during CLEAR and as the
// byte counter during LOAD. One bit wider than the address so a full load reads 256.
module ld_addr_gen
  import loader_pkg::*;
#(
  parameter int MEM_DEPTH = LD_MEM_DEPTH,
  parameter int ADDR_W    = LD_ADDR_W
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_clr,
  input  logic            i_inc,
  output logic [ADDR_W:0] o_count,
  output logic            o_at_max
);

  localparam logic [ADDR_W:0] LP_MAX = (ADDR_W + 1)'(MEM_DEPTH - 1);

  logic [ADDR_W:0] r_count;

  // Clear has priority so a start or end-of-clear always lands on zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count  = r_count;
  assign o_at_max = (r_count == LP_MAX);

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: optionally zero-fills memory, writes a byte stream
// to consecutive addresses from 0, then releases the processor via o_cpu_run.
module prog_loader
  import loader_pkg::*;
#(
  parameter int MEM_DEPTH = LD_MEM_DEPTH,
  parameter int ADDR_W    = LD_ADDR_W,
  parameter int DATA_W    = 8,
  parameter int CLEAR_EN  = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic              i_in_last,
  output logic              o_in_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_cpu_run,
  output logic              o_load_done,
  output logic [ADDR_W:0]   o_byte_count,
  output logic              o_err_overflow
);

  ld_state_e         r_state;
  ld_state_e         w_state_nxt;

  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_cpu_run;
  logic              r_load_done;
  logic              r_err_overflow;

  logic              w_we_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_wdata_nxt;
  logic              w_run_nxt;
  logic              w_done_nxt;
  logic              w_err_nxt;

  logic              w_cnt_clr;
  logic              w_cnt_inc;
  logic [ADDR_W:0]   w_count;
  logic              w_at_max;

  ld_addr_gen #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_addr_gen (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (w_cnt_clr),
    .i_inc    (w_cnt_inc),
    .o_count  (w_count),
    .o_at_max (w_at_max)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= IDLE;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_cpu_run      <= 1'b0;
      r_load_done    <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_mem_we       <= w_we_nxt;
      r_mem_addr     <= w_addr_nxt;
      r_mem_wdata    <= w_wdata_nxt;
      r_cpu_run      <= w_run_nxt;
      r_load_done    <= w_done_nxt;
      r_err_overflow <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = r_mem_addr;
    w_wdata_nxt = r_mem_wdata;
    w_run_nxt   = r_cpu_run;
    w_done_nxt  = 1'b0;
    w_err_nxt   = r_err_overflow;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;

    unique case (r_state)
      IDLE, ERR: begin
        if (i_start) begin
          w_state_nxt = ld_first_state(CLEAR_EN != 0);
          w_cnt_clr   = 1'b1;
          w_err_nxt   = 1'b0;
        end
      end

      // The counter doubles as clear pointer; it is zeroed again on the way
      // into LOAD so the first stream byte lands at address 0.
      CLEAR: begin
        w_we_nxt    = 1'b1;
        w_addr_nxt  = w_count[ADDR_W-1:0];
        w_wdata_nxt = '0;
        if (w_at_max) begin
          w_state_nxt = LOAD;
          w_cnt_clr   = 1'b1;
        end else begin
          w_cnt_inc   = 1'b1;
        end
      end

      LOAD: begin
        if (i_in_valid) begin
          w_we_nxt    = 1'b1;
          w_addr_nxt  = w_count[ADDR_W-1:0];
          w_wdata_nxt = i_in_data;
          w_cnt_inc   = 1'b1;
          if (i_in_last) begin
            w_state_nxt = RUN;
          end else if (w_at_max) begin
            w_state_nxt = ERR;
            w_err_nxt   = 1'b1;
          end
        end
      end

      // cpu_run rises one edge after RUN entry, so the final write has
      // already been committed to memory before the first fetch.
      RUN: begin
        if (i_start) begin
          w_run_nxt   = 1'b0;
          w_state_nxt = ld_first_state(CLEAR_EN != 0);
          w_cnt_clr   = 1'b1;
          w_err_nxt   = 1'b0;
        end else begin
          w_run_nxt   = 1'b1;
          w_done_nxt  = !r_cpu_run;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign o_in_ready     = (r_state == LOAD);
  assign o_mem_we       = r_mem_we;
  assign o_mem_addr     = r_mem_addr;
  assign o_mem_wdata    = r_mem_wdata;
  assign o_cpu_run      = r_cpu_run;
  assign o_load_done    = r_load_done;
  assign o_err_overflow = r_err_overflow;
  // While clearing, the shared counter holds the clear pointer, not a byte count.
  assign o_byte_count   = (r_state == CLEAR) ? '0 : w_count;

endmodule
